muldiv_exec_element: RTL

// - Parametrised multi-cycle multiply/divide execution element for the exec stage.
// - Adds to the single-width ALU element: high-half products, unsigned ops, remainder,
//   and a radix-2^k iterative divider with divide-by-zero and overflow fast paths.
// - Uses a start/busy/done handshake, plus a flush that aborts an operation in flight.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/iter_divider.sv | 79 +++++++
 rtl/muldiv_exec_element.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide execution element: op encodings, FSM states
// and small op-classification helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_PIPE = 3'd1,
        ST_DIV_PREP = 3'd2,
        ST_DIV_ITER = 3'd3,
        ST_DIV_FIX  = 3'd4
    } muldiv_state_t;

    function automatic logic is_div_op(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_mul_high(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/iter_divider.sv
// Unsigned restoring divider core, DIV_BITS quotient bits per cycle. The first
// step is folded into the load cycle, so results are valid WIDTH/DIV_BITS edges after load.
module iter_divider #(
    parameter int WIDTH    = 32,
    parameter int DIV_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int ITERS = WIDTH / DIV_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem_in,
                                                    input logic [WIDTH-1:0] quo_in,
                                                    input logic [WIDTH-1:0] dsr);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        rem = rem_in;
        quo = quo_in;
        for (int i = 0; i < DIV_BITS; i++) begin
            r   = {rem, quo[WIDTH-1]};
            quo = {quo[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, dsr}) begin
                r      = r - {1'b0, dsr};
                quo[0] = 1'b1;
            end
            rem = r[WIDTH-1:0];
        end
        return {rem, quo};
    endfunction

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        if (load) begin
            {rem_d, quo_d} = div_step('0, dividend, divisor);
            dsr_d          = divisor;
            cnt_d          = CNT_INIT;
        end else if (cnt_q != '0) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dsr_q);
            cnt_d          = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = (cnt_q == '0);

endmodule

// File: rtl/muldiv_exec_element.sv
// Multi-cycle multiply/divide element: pipelined multiplier, iterative divider with
// b==0 / signed-overflow fast paths, start/busy/done handshake and flush abort.
module muldiv_exec_element
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output muldiv_state_t    dbg_state
);

    // Handshake: start is taken on a rising edge only when busy == 0 and flush == 0;
    // done pulses for exactly one cycle with result/div_by_zero valid and busy already low.

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = '1;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             accept, div_load;

    logic [MUL_STAGES:0]  mul_vld_q, mul_vld_d;
    logic [2*WIDTH-1:0]   prod_q [MUL_STAGES];
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod_c;
    logic [WIDTH-1:0]     mul_result;

    logic             div_signed, b_zero, ovf, fast;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] fix_q, fix_r, div_result;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic             div_valid;

    // Sign-extending into 2*WIDTH makes a plain truncated product correct for all signedness mixes.
    always_comb begin
        a_ext  = {{WIDTH{((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[WIDTH-1]}}, a_q};
        b_ext  = {{WIDTH{(op_q == OP_MULH) & b_q[WIDTH-1]}}, b_q};
        prod_c = a_ext * b_ext;
        mul_result = is_mul_high(op_q) ? prod_q[MUL_STAGES-1][2*WIDTH-1:WIDTH]
                                       : prod_q[MUL_STAGES-1][WIDTH-1:0];
    end

    always_comb begin
        div_signed = is_signed_div(op_q);
        b_zero     = (b_q == '0);
        ovf        = div_signed && (a_q == MIN_VAL) && (b_q == ONES);
        fast       = b_zero || ovf;
        a_neg      = div_signed & a_q[WIDTH-1];
        b_neg      = div_signed & b_q[WIDTH-1];
        a_mag      = a_neg ? -a_q : a_q;
        b_mag      = b_neg ? -b_q : b_q;
        fix_q      = (a_neg ^ b_neg) ? -div_quo : div_quo;
        fix_r      = a_neg ? -div_rem : div_rem;
        if (b_zero) begin
            fix_q = ONES;
            fix_r = a_q;
        end else if (ovf) begin
            fix_q = MIN_VAL;
            fix_r = '0;
        end
        div_result = is_rem_op(op_q) ? fix_r : fix_q;
    end

    iter_divider #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clk       (clk),
        .rst_n     (reset),
        .load      (div_load),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        div_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = is_div_op(op) ? ST_DIV_PREP : ST_MUL_PIPE;
                end
            end
            ST_MUL_PIPE: begin
                if (mul_vld_q[MUL_STAGES]) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = mul_result;
                    dbz_d    = 1'b0;
                end
            end
            ST_DIV_PREP: begin
                if (fast) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    state_d  = ST_DIV_ITER;
                    div_load = 1'b1;
                end
            end
            ST_DIV_ITER: begin
                if (div_valid) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                result_d = div_result;
                dbz_d    = b_zero;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides everything, including a start in IDLE and a completing op.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            dbz_d    = dbz_q;
            done_d   = 1'b0;
            accept   = 1'b0;
            div_load = 1'b0;
        end
        op_d      = accept ? op : op_q;
        a_d       = accept ? a : a_q;
        b_d       = accept ? b : b_q;
        mul_vld_d = flush ? '0 : {mul_vld_q[MUL_STAGES-1:0], accept & ~is_div_op(op)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            mul_vld_q <= '0;
            for (int k = 0; k < MUL_STAGES; k++) prod_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            mul_vld_q <= mul_vld_d;
            prod_q[0] <= prod_c;
            for (int k = 1; k < MUL_STAGES; k++) prod_q[k] <= prod_q[k-1];
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule
